// File: rtl/binary_to_residue_seq_if.sv
// binary_to_residue_seq_if
//   Handshake bundle between an operand source, the binary-to-residue converter
//   and the residue consumer.
//
//   Input side : in_valid/in_ready handshake carrying in_x (operand) and in_m (modulus).
//   Output side: out_valid/out_ready handshake carrying out_r (residue) and out_err
//                (zero-modulus flag).
//
//   master : the environment (source and consumer).
//   slave  : the converter.
interface binary_to_residue_seq_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned MOD_W  = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_x;
   logic [MOD_W-1:0]  in_m;
   logic              out_valid;
   logic              out_ready;
   logic [MOD_W-1:0]  out_r;
   logic              out_err;

   modport master (
      output in_valid,
      output in_x,
      output in_m,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_r,
      input  out_err
   );

   modport slave (
      input  in_valid,
      input  in_x,
      input  in_m,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_r,
      output out_err
   );
endinterface

// File: rtl/binary_to_residue_seq.sv
// binary_to_residue_seq
//   Sequential forward converter: reduces an unsigned DATA_W-bit operand modulo a
//   runtime MOD_W-bit modulus by restoring shift-and-subtract, one operand bit per
//   clock. The residue is always normalised to 0..m-1. A zero modulus finishes
//   immediately with out_err set and out_r = 0.
//
// Ports
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : slave side of binary_to_residue_seq_if
//         in_valid/in_ready, in_x, in_m   - operand handshake (sampled on accept only)
//         out_valid/out_ready, out_r, out_err - result handshake (held until accepted)
//
// Latency: result valid DATA_W edges after the accept edge (zero modulus: visible
// right after the accept edge). Throughput: one result per DATA_W+2 cycles.
module binary_to_residue_seq #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned MOD_W  = 4
) (
   input logic                    clk,
   input logic                    rst,
   binary_to_residue_seq_if.slave bus
);

   localparam int unsigned CntW = $clog2(DATA_W + 1);
   localparam logic [CntW-1:0] LastStep = CntW'(DATA_W - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e            state_q;
   logic [DATA_W-1:0] x_q;    // operand, consumed MSB first
   logic [MOD_W-1:0]  m_q;    // latched modulus
   logic [MOD_W:0]    r_q;    // partial remainder, one guard bit
   logic [CntW-1:0]   cnt_q;  // completed RUN steps
   logic              out_valid_q;
   logic [MOD_W-1:0]  out_r_q;
   logic              out_err_q;

   // One restoring step: bring in the next operand bit, subtract M if it fits.
   logic [MOD_W:0] step_t;
   logic [MOD_W:0] step_diff;
   logic           step_ge;
   logic [MOD_W:0] r_next;

   always_comb begin
      step_t    = {r_q[MOD_W-1:0], x_q[DATA_W-1]};
      step_diff = step_t - {1'b0, m_q};
      step_ge   = (step_t >= {1'b0, m_q});
      r_next    = step_ge ? step_diff : step_t;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         x_q         <= '0;
         m_q         <= '0;
         r_q         <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_r_q     <= '0;
         out_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // in_ready is high whenever we are idle and out of reset.
               if (bus.in_valid) begin
                  x_q   <= bus.in_x;
                  m_q   <= bus.in_m;
                  r_q   <= '0;
                  cnt_q <= '0;
                  if (bus.in_m == '0) begin
                     state_q     <= StDone;
                     out_valid_q <= 1'b1;
                     out_r_q     <= '0;
                     out_err_q   <= 1'b1;
                  end else begin
                     state_q <= StRun;
                  end
               end
            end

            StRun: begin
               r_q   <= r_next;
               x_q   <= x_q << 1;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LastStep) begin
                  state_q     <= StDone;
                  out_valid_q <= 1'b1;
                  out_r_q     <= r_next[MOD_W-1:0];
                  out_err_q   <= 1'b0;
               end
            end

            StDone: begin
               // Result stays put until the consumer takes it.
               if (bus.out_ready) begin
                  state_q     <= StIdle;
                  out_valid_q <= 1'b0;
               end
            end

            default: begin
               state_q     <= StIdle;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_q == StIdle) && !rst;
   assign bus.out_valid = out_valid_q;
   assign bus.out_r     = out_r_q;
   assign bus.out_err   = out_err_q;

   // The remainder stays below M after every step, so the guard bit never sets
   // and every delivered residue is already in range.
   a_guard_clear: assert property (@(posedge clk) disable iff (rst) !r_q[MOD_W]);
   a_residue_in_range: assert property (@(posedge clk) disable iff (rst)
      (out_valid_q && !out_err_q) |-> (out_r_q < m_q));

endmodule
